fetch_decode_queue: RTL and testbench
=====================================

// Module: fetch_decode_queue
// PURPOSE
//   Instruction queue between the fetch stage (PC + instruction memory) and decode.
//   Captures {PC, instruction} pairs from fetch and presents them in order to decode
//   through a valid/ready handshake, so decode stalls are absorbed without losing
//   fetched words. Branch/jump redirects use flush_i to discard every queued entry.
// PARAMETERS
//   DEPTH  2              number of entries; power of two, >= 2
//   XLEN   32             width of the PC and instruction fields
//   NOP    32'h00000013   instruction driven on dec_instr_o while the queue is empty (addi x0,x0,0)
// PORTS
//   clk            input   1               rising-edge clock
//   rst            input   1               synchronous reset, active-high
//   fetch_valid_i  input   1               fetch presents a valid {pc, instr} pair
//   fetch_pc_i     input   XLEN            PC of the fetched instruction
//   fetch_instr_i  input   XLEN            fetched instruction word
//   fetch_ready_o  output  1               queue can accept a pair this cycle
//   flush_i        input   1               discard all entries (control-flow redirect)
//   dec_valid_o    output  1               head entry is valid
//   dec_pc_o       output  XLEN            PC of the head entry
//   dec_instr_o    output  XLEN            instruction of the head entry
//   dec_ready_i    input   1               decode consumes the head entry this cycle
//   count_o        output  $clog2(DEPTH)+1 number of occupied entries
// BEHAVIOUR
//   - Circular buffer: wr_ptr, rd_ptr wrap modulo DEPTH. count_o ranges 0..DEPTH.
//   - push = fetch_valid_i & fetch_ready_o & ~flush_i
//   - pop  = dec_valid_o & dec_ready_i & ~flush_i
//   - fetch_ready_o = (count_o != DEPTH). No pop-bypass: a full queue rejects pushes
//     even when pop is asserted in the same cycle.
//   - dec_valid_o = (count_o != 0). dec_pc_o/dec_instr_o read the head entry
//     combinationally. When empty: dec_pc_o = 0 and dec_instr_o = NOP.
//   - Latency: a pair pushed at edge N is visible on dec_* after edge N (one cycle).
//     There is no fall-through path from fetch_* to dec_* while the queue is empty.
//   - Push and pop in the same cycle (0 < count < DEPTH): count unchanged, both pointers advance.
//   - Push only: count+1. Pop only: count-1. Neither: all state holds.
//   - fetch_valid_i while full: the pair is not written. Fetch must hold it.
//   - flush_i at an edge: count, wr_ptr, rd_ptr <- 0. A same-cycle push and pop are
//     both discarded. The queue is empty and ready on the next cycle.
//   - Priority: rst > flush_i > push/pop.
//   - Reset at the edge: count_o=0, dec_valid_o=0, fetch_ready_o=1, dec_pc_o=0,
//     dec_instr_o=NOP, pointers=0. Storage arrays are not reset. Reset asserted
//     mid-stream drops all entries exactly like a flush.
//   - Input and output ports have no combinational dependence, except through
//     count-derived flags. fetch_ready_o does not depend on dec_ready_i.
// TESTING
//   1. Reset: assert rst 2 cycles -> dec_valid_o=0, dec_instr_o=32'h00000013,
//      dec_pc_o=0, fetch_ready_o=1, count_o=0.
//   2. Stream: push (0x0,0x00500093),(0x4,0x00A00113) with dec_ready_i=1 -> decode
//      sees them one cycle after each push, in order. count_o never exceeds 1.
//   3. Fill/stall: dec_ready_i=0, push 0x0,0x4 -> count_o=2, fetch_ready_o=0. Offer 0x8
//      -> not accepted. Raise dec_ready_i -> outputs 0x0 then 0x4. fetch_ready_o=1
//      the cycle after the first pop.
//   4. Simultaneous: count_o=1 (pc 0x10), push 0x14 and pop the same cycle -> count_o
//      stays 1, head becomes 0x14.
//   5. Flush: count_o=2, assert flush_i with fetch_valid_i=1 (pc 0x40) -> next cycle
//      count_o=0, dec_valid_o=0, and 0x40 is never delivered.
//   6. Wrap: 5 push/pop pairs with DEPTH=2 -> PCs 0x0..0x10 delivered in order,
//      with no duplicates or drops.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular buffer of
// {pc, instr} pairs with valid/ready handshakes on both sides and a flush for redirects.
module fetch_decode_queue #(
    parameter int              DEPTH = 2,
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] NOP   = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_valid_i,
    input  logic [XLEN-1:0]          fetch_pc_i,
    input  logic [XLEN-1:0]          fetch_instr_i,
    output logic                     fetch_ready_o,
    input  logic                     flush_i,
    output logic                     dec_valid_o,
    output logic [XLEN-1:0]          dec_pc_o,
    output logic [XLEN-1:0]          dec_instr_o,
    input  logic                     dec_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshake: a pair moves on a side when its valid and ready are both high at
    // the rising edge and flush_i is low; flush_i cancels both transfers.
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    // Ready only looks at occupancy, so a full queue never takes a word even while popping.
    assign fetch_ready_o = (count != CW'(DEPTH));
    assign dec_valid_o   = (count != '0);
    assign count_o       = count;
    assign push          = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign pop           = dec_valid_o & dec_ready_i & ~flush_i;
    assign dec_pc_o      = dec_valid_o ? pc_mem[rd_ptr]    : '0;
    assign dec_instr_o   = dec_valid_o ? instr_mem[rd_ptr] : NOP;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage carries no reset; entries are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr]    <= fetch_pc_i;
            instr_mem[wr_ptr] <= fetch_instr_i;
        end
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed scenarios then random traffic, every cycle
// compared with a queue-based model of the fetch/decode buffer.
module tb_fetch_decode_queue;
    localparam int              DEPTH = 2;
    localparam int              XLEN  = 32;
    localparam int              CW    = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] NOP   = 32'h00000013;

    logic            clk;
    logic            rst;
    logic            fetch_valid_i;
    logic [XLEN-1:0] fetch_pc_i;
    logic [XLEN-1:0] fetch_instr_i;
    logic            fetch_ready_o;
    logic            flush_i;
    logic            dec_valid_o;
    logic [XLEN-1:0] dec_pc_o;
    logic [XLEN-1:0] dec_instr_o;
    logic            dec_ready_i;
    logic [CW-1:0]   count_o;

    fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid_i (fetch_valid_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_instr_i (fetch_instr_i),
        .fetch_ready_o (fetch_ready_o),
        .flush_i       (flush_i),
        .dec_valid_o   (dec_valid_o),
        .dec_pc_o      (dec_pc_o),
        .dec_instr_o   (dec_instr_o),
        .dec_ready_i   (dec_ready_i),
        .count_o       (count_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: entries held as {pc, instr}, head at index 0
    logic [2*XLEN-1:0] exp_q[$];
    bit                model_known;
    int                checks;
    int                errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [2*XLEN-1:0] head;
        int n;
        n    = exp_q.size();
        head = (n != 0) ? exp_q[0] : {{XLEN{1'b0}}, NOP};
        check("count", 64'(count_o), 64'(n));
        check("dec_valid", 64'(dec_valid_o), 64'(n != 0));
        check("fetch_ready", 64'(fetch_ready_o), 64'(n != DEPTH));
        check("dec_pc", 64'(dec_pc_o), 64'(head[2*XLEN-1:XLEN]));
        check("dec_instr", 64'(dec_instr_o), 64'(head[XLEN-1:0]));
    endtask

    // driver: apply inputs just after an edge, check before the next edge, advance model
    task automatic step(input logic r, input logic fv, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] ins, input logic fl, input logic dr);
        bit do_push;
        bit do_pop;
        rst           = r;
        fetch_valid_i = fv;
        fetch_pc_i    = pc;
        fetch_instr_i = ins;
        flush_i       = fl;
        dec_ready_i   = dr;
        #1;
        if (model_known) check_outputs();
        do_push = fv && (exp_q.size() < DEPTH) && !fl;
        do_pop  = (exp_q.size() > 0) && dr && !fl;
        @(posedge clk);
        if (r || fl) begin
            exp_q.delete();
            if (r) model_known = 1'b1;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({pc, ins});
        end
        #1;
    endtask

    task automatic idle(input logic dr);
        step(1'b0, 1'b0, '0, '0, 1'b0, dr);
    endtask

    logic [XLEN-1:0] pc_gen;

    initial begin
        checks        = 0;
        errors        = 0;
        model_known   = 1'b0;
        rst           = 1'b1;
        fetch_valid_i = 1'b0;
        fetch_pc_i    = '0;
        fetch_instr_i = '0;
        flush_i       = 1'b0;
        dec_ready_i   = 1'b0;
        @(posedge clk);
        #1;

        // reset for two cycles, then fixed reset values
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        check("rst_valid", 64'(dec_valid_o), 64'd0);
        check("rst_instr", 64'(dec_instr_o), 64'h13);
        check("rst_pc", 64'(dec_pc_o), 64'd0);
        check("rst_ready", 64'(fetch_ready_o), 64'd1);
        check("rst_count", 64'(count_o), 64'd0);

        // streaming with decode always ready
        step(1'b0, 1'b1, 32'h0, 32'h00500093, 1'b0, 1'b1);
        check("stream_pc0", 64'(dec_pc_o), 64'h0);
        step(1'b0, 1'b1, 32'h4, 32'h00A00113, 1'b0, 1'b1);
        check("stream_pc1", 64'(dec_pc_o), 64'h4);
        check("stream_count", 64'(count_o), 64'd1);
        idle(1'b1);

        // fill while stalled, offer a third, then drain
        step(1'b0, 1'b1, 32'h0, 32'h11, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h4, 32'h22, 1'b0, 1'b0);
        check("full_count", 64'(count_o), 64'd2);
        check("full_ready", 64'(fetch_ready_o), 64'd0);
        step(1'b0, 1'b1, 32'h8, 32'h33, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h8, 32'h33, 1'b0, 1'b1);
        check("after_pop_ready", 64'(fetch_ready_o), 64'd1);
        check("after_pop_head", 64'(dec_pc_o), 64'h4);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // simultaneous push and pop at count 1
        step(1'b0, 1'b1, 32'h10, 32'h44, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h14, 32'h55, 1'b0, 1'b1);
        check("simul_count", 64'(count_o), 64'd1);
        check("simul_head", 64'(dec_pc_o), 64'h14);
        idle(1'b1);

        // flush with a competing push
        step(1'b0, 1'b1, 32'h20, 32'h66, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h24, 32'h77, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h40, 32'h88, 1'b1, 1'b1);
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_valid", 64'(dec_valid_o), 64'd0);
        idle(1'b1);

        // pointer wrap: five back-to-back pairs
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, XLEN'(4 * i), XLEN'(32'h100 + i), 1'b0, 1'b1);
            check("wrap_head", 64'(dec_pc_o), 64'(4 * i));
        end
        idle(1'b1);

        // random traffic including flushes and mid-stream resets
        pc_gen = 32'h1000;
        for (int i = 0; i < 2000; i++) begin
            logic fv;
            fv = ($urandom_range(0, 3) != 0);
            step(($urandom_range(0, 99) == 0), fv, pc_gen, $urandom,
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
            if (fv) pc_gen = pc_gen + 32'd4;
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
